// File: rtl/alu_seq_if.sv
// Handshake bundle between the datapath controller (master) and alu_seq (slave).
// The controller drives start/op/operands; the ALU returns result, flags and status.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] rdest;
  logic [WIDTH-1:0] rsrc;
  logic [WIDTH-1:0] result;
  logic             wr_en;
  logic [4:0]       flags;
  logic             busy;
  logic             done;

  modport master (
    output start, op, rdest, rsrc,
    input  result, wr_en, flags, busy, done
  );

  modport slave (
    input  start, op, rdest, rsrc,
    output result, wr_en, flags, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with PSR flags (CLFZN): single-cycle ops complete one edge after start.
// MUL is shift-add over WIDTH steps; busy stalls the controller and start is ignored meanwhile.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);
  typedef struct packed {
    logic n;
    logic z;
    logic f;
    logic l;
    logic c;
  } flags_t;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_CMP  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd6;
  localparam logic [4:0] OP_LSH  = 5'd7;
  localparam logic [4:0] OP_RSH  = 5'd8;
  localparam logic [4:0] OP_ARSH = 5'd9;
  localparam logic [4:0] OP_MUL  = 5'd10;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  logic [0:0]         state;
  logic [WIDTH-1:0]   result_q;
  flags_t             flags_q;
  logic               wr_en_q;
  logic               done_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW:0]       cnt;

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   sum;
  logic [SHW-1:0]     shamt;
  logic               is_sub;
  flags_t             arith_flags;
  logic [WIDTH-1:0]   alu_res;
  flags_t             alu_flags;
  logic               alu_wr;
  logic [2*WIDTH-1:0] acc_next;

  assign a      = bus.rdest;
  assign b      = bus.rsrc;
  assign shamt  = bus.rsrc[SHW-1:0];
  assign is_sub = (bus.op == OP_SUB) || (bus.op == OP_CMP);

  // Subtraction reuses the adder as a + ~b + 1 so C reads as "no borrow".
  assign b_eff   = is_sub ? ~b : b;
  assign sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign sum     = sum_ext[WIDTH-1:0];

  always_comb begin
    arith_flags   = '0;
    arith_flags.c = sum_ext[WIDTH];
    arith_flags.l = a < b;
    arith_flags.n = $signed(a) < $signed(b);
    arith_flags.z = (sum == '0);
    if (is_sub)
      arith_flags.f = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else
      arith_flags.f = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  always_comb begin
    alu_res   = result_q;
    alu_flags = flags_q;
    alu_wr    = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB: begin
        alu_res   = sum;
        alu_flags = arith_flags;
        alu_wr    = 1'b1;
      end
      OP_CMP:  alu_flags = arith_flags;
      OP_AND:  begin alu_res = a & b;  alu_wr = 1'b1; end
      OP_OR:   begin alu_res = a | b;  alu_wr = 1'b1; end
      OP_XOR:  begin alu_res = a ^ b;  alu_wr = 1'b1; end
      OP_NOT:  begin alu_res = ~b;     alu_wr = 1'b1; end
      OP_LSH:  begin alu_res = a << shamt; alu_wr = 1'b1; end
      OP_RSH:  begin alu_res = a >> shamt; alu_wr = 1'b1; end
      OP_ARSH: begin alu_res = $signed(a) >>> shamt; alu_wr = 1'b1; end
      default: ;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      wr_en_q  <= 1'b0;
      done_q   <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            state  <= S_MUL;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CNT_INIT;
          end else begin
            done_q   <= 1'b1;
            wr_en_q  <= alu_wr;
            result_q <= alu_res;
            flags_q  <= alu_flags;
          end
        end
      end else begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNT_ONE;
        // Last step: publish the low half, F flags a non-zero high half.
        if (cnt == CNT_ONE) begin
          state     <= S_IDLE;
          done_q    <= 1'b1;
          wr_en_q   <= 1'b1;
          result_q  <= acc_next[WIDTH-1:0];
          flags_q.z <= (acc_next[WIDTH-1:0] == '0);
          flags_q.f <= |acc_next[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign bus.result = result_q;
  assign bus.flags  = flags_q;
  assign bus.wr_en  = wr_en_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state == S_MUL);
endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq (WIDTH=16) against an arithmetic reference model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [15:0] m_res;
  logic [4:0]  m_flags;
  logic        m_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the operand values, flags packed {N,Z,F,L,C}.
  task automatic model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    int     s = int'(b[3:0]);
    bit c, l, f, z, n;
    l = ua < ub;
    n = sa < sb;
    m_wr = 1'b1;
    case (op)
      5'd0: begin
        r = ua + ub;
        c = r > 65535;
        f = (sa + sb > 32767) || (sa + sb < -32768);
        z = (r % 65536) == 0;
        m_res = 16'(r);
        m_flags = {n, z, f, l, c};
      end
      5'd1, 5'd2: begin
        r = ua - ub;
        c = ua >= ub;
        f = (sa - sb > 32767) || (sa - sb < -32768);
        z = ua == ub;
        if (op == 5'd1) m_res = 16'(r);
        else m_wr = 1'b0;
        m_flags = {n, z, f, l, c};
      end
      5'd3: m_res = a & b;
      5'd4: m_res = a | b;
      5'd5: m_res = a ^ b;
      5'd6: m_res = ~b;
      5'd7: m_res = 16'((ua << s) & 65535);
      5'd8: m_res = 16'(ua >> s);
      5'd9: m_res = 16'((sa >>> s) & 65535);
      5'd10: begin
        r = ua * ub;
        m_res = 16'(r);
        m_flags[3] = (r % 65536) == 0;
        m_flags[2] = r > 65535;
      end
      default: m_wr = 1'b0;
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge where done should be high.
  // start stays asserted so consecutive calls run back-to-back.
  task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rdest = a;
    bus.rsrc  = b;
    model(op, a, b);
    @(negedge clk);
    if (op == 5'd10) begin
      for (int i = 0; i < W; i++) begin
        check("mul_busy", bus.busy, 1);
        check("mul_no_done", bus.done, 0);
        bus.rdest = 16'($urandom);
        bus.rsrc  = 16'($urandom);
        @(negedge clk);
      end
    end
    check("busy_clear", bus.busy, 0);
    check("done", bus.done, 1);
    check("result", bus.result, m_res);
    check("flags", bus.flags, m_flags);
    check("wr_en", bus.wr_en, m_wr);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.rdest = '0;
    bus.rsrc  = '0;
    m_res     = '0;
    m_flags   = '0;
    m_wr      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_result", bus.result, 0);
    check("rst_flags", bus.flags, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    reset = 1'b0;
    @(negedge clk);

    run_op(5'd0, 16'h7FFF, 16'h0001);
    check("add_ovf_res", bus.result, 16'h8000);
    check("add_ovf_flags", bus.flags, 5'b00100);
    bus.start = 1'b0;
    @(negedge clk);
    check("add_done_drop", bus.done, 0);

    run_op(5'd1, 16'h0003, 16'h0005);
    check("sub_res", bus.result, 16'hFFFE);
    check("sub_flags", bus.flags, 5'b10010);
    run_op(5'd2, 16'h1234, 16'h1234);
    check("cmp_eq_flags", bus.flags, 5'b01001);
    check("cmp_keep_res", bus.result, 16'hFFFE);
    run_op(5'd2, 16'h8000, 16'h0001);
    check("cmp_neg_flags", bus.flags, 5'b10101);

    run_op(5'd9, 16'h8000, 16'h0004);
    check("arsh_res", bus.result, 16'hF800);
    run_op(5'd8, 16'h8000, 16'h0004);
    check("rsh_res", bus.result, 16'h0800);
    run_op(5'd7, 16'h8000, 16'h0011);
    check("lsh_res", bus.result, 16'h0000);
    check("shift_flags_kept", bus.flags, 5'b10101);

    run_op(5'd10, 16'h0100, 16'h0100);
    check("mul_wrap_res", bus.result, 16'h0000);
    run_op(5'd10, 16'h00FF, 16'h0003);
    check("mul_small_res", bus.result, 16'h02FD);
    bus.start = 1'b0;
    @(negedge clk);
    check("mul_done_drop", bus.done, 0);

    bus.start = 1'b1;
    bus.op    = 5'd10;
    bus.rdest = 16'h1234;
    bus.rsrc  = 16'h5678;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", bus.busy, 1);
    reset     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, 0);
    check("abort_flags", bus.flags, 0);
    m_res   = '0;
    m_flags = '0;
    reset   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_late_done", bus.done, 0);
    end
    run_op(5'd0, 16'h0001, 16'h0001);
    check("add_after_reset", bus.result, 16'h0002);

    for (int i = 0; i < 300; i++) begin
      logic [4:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      op = 5'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (i % 7 == 0) b = a;
      if (i % 11 == 0) a = 16'h8000;
      run_op(op, a, b);
    end
    run_op(5'd31, 16'hAAAA, 16'h5555);
    bus.start = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's combinational 16-bit ALU. It executes the same ten-opcode set (ADD, SUB, CMP, AND, OR, XOR, NOT, LSH, RSH, ARSH) at any `WIDTH`, adds variable shift amounts and a multi-cycle unsigned multiply (MUL), and holds the CLFZN flags in an internal processor-status register. It sits between the register file and the writeback mux and uses a start/busy/done handshake, so the datapath controller can stall on multi-cycle operations.

## Interface
- `WIDTH`, 16: operand/result width; must be a power of two, at least 4.
- `SHW`, $clog2(WIDTH): width of the shift-amount field.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset; one clock; reset is synchronous and active-high.
- `start` input 1: request; sampled only when `busy`=0.
- `op` input 5: opcode. ADD=0, SUB=1, CMP=2, AND=3, OR=4, XOR=5, NOT=6, LSH=7, RSH=8, ARSH=9, MUL=10.
- `rdest` input WIDTH: destination operand (A).
- `rsrc` input WIDTH: source operand (B); `rsrc[SHW-1:0]` is the shift amount.
- `result` output WIDTH: registered result.
- `wr_en` output 1: result must be written back. Qualified by `done`.
- `flags` output 5: registered PSR. [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
- `busy` output 1: MUL in progress.
- `done` output 1: one-cycle pulse; `result`/`wr_en`/`flags` are valid while it is high.

## Operation
- Reset values: `result`=0, `flags`=0, `wr_en`=0, `busy`=0, `done`=0, FSM=IDLE.
- The FSM has two states, IDLE and MUL.
- IDLE: `start`=1 with `op`≠MUL completes in one cycle. `start`=1 with `op`=MUL latches the operands, clears the accumulator, loads the counter with WIDTH and goes to MUL.
- MUL: one shift-add step per cycle, low-WIDTH-bit product.
  - The counter decrements each step.
  - When it reaches 0, the FSM returns to IDLE and pulses `done`.
  - `start` is ignored while in MUL.
- Arithmetic is done at WIDTH+1 bits. SUB and CMP compute `rdest + ~rsrc + 1`.
- C is the carry out of bit WIDTH-1. For SUB/CMP, C=1 means no borrow.
- L = unsigned(`rdest`) < unsigned(`rsrc`).
- N = signed(`rdest`) < signed(`rsrc`).
- Z = (WIDTH-bit sum/difference == 0).
- F = signed overflow of the performed operation.
  - ADD: operand signs equal and result sign differs.
  - SUB/CMP: operand signs differ and result sign differs from `rdest`.
- ADD/SUB: update `result` and all five flags; `wr_en`=1.
- CMP: updates all five flags. `result` holds its previous value. `wr_en`=0.
- AND, OR, XOR: `rdest` op `rsrc`.
- NOT: bitwise `~rsrc`.
- Shifts act on `rdest` by `rsrc[SHW-1:0]`; upper `rsrc` bits are ignored.
  - LSH: logical left.
  - RSH: logical right.
  - ARSH: sign-filling right.
- Logic ops and shifts: `wr_en`=1 and flags are unchanged.
- MUL: `result` = low WIDTH bits of the product; `wr_en`=1.
  - Z = (low half == 0).
  - F = (high half ≠ 0).
  - C, L and N are unchanged.
- Undefined opcodes (11–31): `result` unchanged, flags unchanged, `wr_en`=0. `done` still pulses so the controller never hangs.
- Reset mid-MUL aborts the operation. No `done` is produced, and all outputs return to their reset values the following cycle.

## Timing
- Single-cycle ops:
  - `start` is sampled at edge E.
  - `result`, `flags`, `wr_en` and `done`=1 are visible after edge E.
  - `done` drops after E+1 unless another request is accepted at E+1.
- Back-to-back: one single-cycle op can be accepted per cycle, with `done` held high continuously.
- MUL:
  - Accepted at edge E; `busy`=1 after E.
  - Steps occur at edges E+1 … E+WIDTH.
  - After E+WIDTH: `busy`=0, `done`=1 and `result` is valid. Latency is WIDTH+1 edges including acceptance.
  - A new `start` is accepted at edge E+WIDTH+1, the same cycle `done` is high.
- Outputs change only on `clk` edges. No combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=16.
- ADD `rdest`=0x7FFF, `rsrc`=0x0001 → `result`=0x8000, C=0, F=1, Z=0, `wr_en`=1, `done` for exactly one cycle.
- SUB `rdest`=0x0003, `rsrc`=0x0005 → `result`=0xFFFE, C=0, L=1, N=1, Z=0, F=0. Follow with CMP 0x1234 vs 0x1234 → Z=1, C=1, `wr_en`=0, `result` still 0xFFFE.
- CMP `rdest`=0x8000, `rsrc`=0x0001 → L=0, N=1, F=1, `wr_en`=0.
- ARSH `rdest`=0x8000, `rsrc`=0x0004 → 0xF800. RSH with the same operands → 0x0800. LSH with `rsrc`=0x0011 (amount 1) → 0x0000. Flags unchanged across all three.
- MUL 0x0100 × 0x0100 with `start` held high throughout:
  - `busy` high for 16 cycles.
  - `done` one cycle later with `result`=0x0000, Z=1, F=1.
  - No second accept during `busy`.
  - MUL 0x00FF × 0x0003 → 0x02FD, F=0.
- Assert `reset` 5 cycles into a MUL → next cycle `busy`=0, `done`=0, `result`=0, `flags`=0, with no late `done`. A subsequent ADD 1+1 → 0x0002 with 1-cycle latency.
